hv_bit_collector: RTL and testbench

//  Downstream stage of the bit-serial neuron. Deserialises the neuron's 1-bit

---
 rtl/hv_pkg.sv | 12 +
 rtl/hv_bit_collector.sv | 118 +++++++++++
 tb/tb_hv_bit_collector.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hv_pkg.sv
// Shared types and sizing helpers for the hypervector bit collector.
package hv_pkg;

  localparam int HV_DIM_DEFAULT = 64;

  function automatic int cnt_w(input int dim);
    return $clog2(dim + 1);
  endfunction

  typedef enum logic {COLLECT, COMPLETE} hvc_state_t;

endpackage

// File: rtl/hv_bit_collector.sv
// Deserialises the neuron's bit stream into an HV_DIM frame while serially
// accumulating popcount, Hamming distance to ref_hv and fire count.
module hv_bit_collector
  import hv_pkg::*;
#(
  parameter int HV_DIM = HV_DIM_DEFAULT,
  parameter int CNT_W  = cnt_w(HV_DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              fire_in,
  input  logic [HV_DIM-1:0] ref_hv,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] hv_out,
  output logic [CNT_W-1:0]  popcount,
  output logic [CNT_W-1:0]  hamming,
  output logic [CNT_W-1:0]  fire_count,
  output logic [7:0]        abort_cnt,
  output logic              drop_err
);

  localparam int              IDX_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(HV_DIM - 1);

  hvc_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [HV_DIM-1:0]  r_sh_hv;
  logic [CNT_W-1:0]   r_sh_pop, r_sh_ham, r_sh_fire;

  logic [IDX_W-1:0]   w_idx;
  logic [HV_DIM-1:0]  w_hv;
  logic [CNT_W-1:0]   w_pop, w_ham, w_fire;
  logic               w_last;

  assign in_ready = (r_state == COLLECT);

  // Next shadow contents for a COLLECT cycle: frame_start rewinds first, so a
  // bit accepted in the same cycle lands at bit 0 of the fresh frame.
  always_comb begin
    w_idx  = r_idx;
    w_hv   = r_sh_hv;
    w_pop  = r_sh_pop;
    w_ham  = r_sh_ham;
    w_fire = r_sh_fire;
    if (frame_start) begin
      w_idx = '0;
      if (r_idx != '0) begin
        w_hv   = '0;
        w_pop  = '0;
        w_ham  = '0;
        w_fire = '0;
      end
    end
    if (bit_valid) begin
      w_hv[w_idx] = bit_in;
      w_pop  = w_pop  + CNT_W'(bit_in);
      w_ham  = w_ham  + CNT_W'(bit_in ^ ref_hv[w_idx]);
      w_fire = w_fire + CNT_W'(fire_in);
    end
    w_last = bit_valid && (w_idx == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= COLLECT;
      r_idx      <= '0;
      r_sh_hv    <= '0;
      r_sh_pop   <= '0;
      r_sh_ham   <= '0;
      r_sh_fire  <= '0;
      out_valid  <= 1'b0;
      hv_out     <= '0;
      popcount   <= '0;
      hamming    <= '0;
      fire_count <= '0;
      abort_cnt  <= '0;
      drop_err   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (bit_valid && !in_ready) drop_err <= 1'b1;
      case (r_state)
        COLLECT: begin
          if (frame_start && r_idx != '0 && abort_cnt != 8'hFF)
            abort_cnt <= abort_cnt + 8'd1;
          r_sh_hv   <= w_hv;
          r_sh_pop  <= w_pop;
          r_sh_ham  <= w_ham;
          r_sh_fire <= w_fire;
          r_idx     <= bit_valid ? w_idx + IDX_W'(1) : w_idx;
          if (w_last) r_state <= COMPLETE;
        end
        COMPLETE: begin
          // Refill may coincide with the consumer's handshake on the old frame.
          if (!out_valid || out_ready) begin
            out_valid  <= 1'b1;
            hv_out     <= r_sh_hv;
            popcount   <= r_sh_pop;
            hamming    <= r_sh_ham;
            fire_count <= r_sh_fire;
            r_sh_hv    <= '0;
            r_sh_pop   <= '0;
            r_sh_ham   <= '0;
            r_sh_fire  <= '0;
            r_idx      <= '0;
            r_state    <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bit_collector.sv
// Directed bench for hv_bit_collector: stream, hamming, backpressure, abort, reset.
module tb_hv_bit_collector;

  localparam int D = 64;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, fire_in = 1'b0;
  logic [D-1:0]  ref_hv = '0;
  logic          in_ready, out_valid;
  logic          out_ready = 1'b0;
  logic [D-1:0]  hv_out;
  logic [CW-1:0] popcount, hamming, fire_count;
  logic [7:0]    abort_cnt;
  logic          drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [D-1:0] X  = 64'hD1A2B1E0_FEDCCAFE;
  localparam logic [D-1:0] F1 = 64'h00000000_0000FFFF;
  localparam logic [D-1:0] F2 = 64'hFFFF0000_00000000;
  localparam logic [D-1:0] PD = 64'h80000000_00000001;
  localparam logic [D-1:0] PE = 64'h55555555_55555555;
  localparam logic [D-1:0] PG = 64'h01234567_89ABCDEF;

  hv_bit_collector #(.HV_DIM(D)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .fire_in(fire_in), .ref_hv(ref_hv), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .hv_out(hv_out),
    .popcount(popcount), .hamming(hamming), .fire_count(fire_count),
    .abort_cnt(abort_cnt), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Streams n bits LSB first, one per cycle while in_ready; optional frame_start on bit 0.
  task automatic feed(input logic [D-1:0] v, input logic [D-1:0] f, input int n, input bit fs_first);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (!in_ready && t < 20) begin
        bit_valid = 1'b0; frame_start = 1'b0;
        @(negedge clk); t++;
      end
      if (!in_ready) begin
        n_tests++; n_fail++;
        $display("FAIL feed_timeout: in_ready=%0d want 1 at bit %0d", in_ready, i);
      end
      bit_valid = 1'b1; bit_in = v[i]; fire_in = f[i];
      frame_start = fs_first && (i == 0);
      @(negedge clk);
    end
    bit_valid = 1'b0; bit_in = 1'b0; fire_in = 1'b0; frame_start = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0d want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0d want 0", out_valid); end
    n_tests++; if ({hv_out, popcount, hamming, fire_count, abort_cnt, drop_err} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: hv=%h pop=%0d ham=%0d fire=%0d abort=%0d drop=%0d want all 0",
                         hv_out, popcount, hamming, fire_count, abort_cnt, drop_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_xor_stream();
    ref_hv = '0;
    feed(64'hDEADBEEF_0123CAFE ^ 64'h0F0F0F0F_FFFF0000, '0, D, 1'b0);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_early_valid: got %0d want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL xor_complete_ready: got %0d want 0", in_ready); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL xor_valid: got %0d want 1", out_valid); end
    n_tests++; if (hv_out !== X) begin n_fail++; $display("FAIL xor_hv: got %h want %h", hv_out, X); end
    n_tests++; if (popcount !== 7'd37) begin n_fail++; $display("FAIL xor_pop: got %0d want 37", popcount); end
    n_tests++; if (hamming !== 7'd37) begin n_fail++; $display("FAIL xor_ham_ref0: got %0d want 37", hamming); end
    n_tests++; if (fire_count !== 7'd0) begin n_fail++; $display("FAIL xor_fire: got %0d want 0", fire_count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL xor_ready_back: got %0d want 1", in_ready); end
    consume();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_consumed: got %0d want 0", out_valid); end
  endtask

  task automatic test_hamming();
    ref_hv = X;
    feed(X, '0, D, 1'b0); @(negedge clk);
    n_tests++; if (hamming !== 7'd0) begin n_fail++; $display("FAIL ham_equal: got %0d want 0", hamming); end
    consume();
    ref_hv = ~X;
    feed(X, '0, D, 1'b0); @(negedge clk);
    n_tests++; if (hamming !== 7'd64) begin n_fail++; $display("FAIL ham_inverse: got %0d want 64", hamming); end
    consume();
    ref_hv = '0;
    feed('1, '1, D, 1'b0); @(negedge clk);
    n_tests++; if (popcount !== 7'd64) begin n_fail++; $display("FAIL ones_pop: got %0d want 64", popcount); end
    n_tests++; if (fire_count !== 7'd64) begin n_fail++; $display("FAIL ones_fire: got %0d want 64", fire_count); end
    n_tests++; if (hamming !== 7'd64) begin n_fail++; $display("FAIL ones_ham: got %0d want 64", hamming); end
    consume();
  endtask

  task automatic test_backpressure();
    ref_hv = '0; out_ready = 1'b0;
    feed(F1, '0, D, 1'b0); @(negedge clk);
    feed(F2, '1, D, 1'b0); @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0d want 0", in_ready); end
    bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0; bit_in = 1'b0;
    n_tests++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL bp_drop: got %0d want 1", drop_err); end
    n_tests++; if (hv_out !== F1 || popcount !== 7'd16 || fire_count !== 7'd0) begin
      n_fail++; $display("FAIL bp_hold: hv=%h pop=%0d fire=%0d want %h 16 0", hv_out, popcount, fire_count, F1); end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || hv_out !== F2 || fire_count !== 7'd64) begin
      n_fail++; $display("FAIL bp_frame2: valid=%0d hv=%h fire=%0d want 1 %h 64", out_valid, hv_out, fire_count, F2); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0d want 1", in_ready); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0d want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    ref_hv = '0;
    feed(64'hFFFFF, '0, 20, 1'b0);
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n_tests++; if (abort_cnt !== 8'd1) begin n_fail++; $display("FAIL abort_cnt1: got %0d want 1", abort_cnt); end
    feed(PD, '0, D, 1'b0); @(negedge clk);
    n_tests++; if (hv_out !== PD || popcount !== 7'd2) begin
      n_fail++; $display("FAIL abort_frame: hv=%h pop=%0d want %h 2", hv_out, popcount, PD); end
    consume();
    feed(64'h3FF, '0, 10, 1'b0);
    feed(PE, '0, D, 1'b1); @(negedge clk);
    n_tests++; if (hv_out !== PE || popcount !== 7'd32 || abort_cnt !== 8'd2) begin
      n_fail++; $display("FAIL abort_same_cycle: hv=%h pop=%0d abort=%0d want %h 32 2", hv_out, popcount, abort_cnt, PE); end
    consume();
    frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
    n_tests++; if (abort_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_idx0: got %0d want 2", abort_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    ref_hv = '0;
    feed(PD, '0, D, 1'b0); @(negedge clk);
    feed(64'hFFFF_FFFF, '1, 30, 1'b0);
    rst_n = 1'b0; #1;
    n_tests++; if ({out_valid, hv_out, popcount, hamming, fire_count, abort_cnt, drop_err} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst: valid=%0d hv=%h abort=%0d drop=%0d ready=%0d want 0 0 0 0 1",
                         out_valid, hv_out, abort_cnt, drop_err, in_ready); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    feed(PG, '0, D, 1'b0); @(negedge clk);
    n_tests++; if (hv_out !== PG || popcount !== 7'd32 || hamming !== 7'd32 || fire_count !== 7'd0) begin
      n_fail++; $display("FAIL mid_rst_frame: hv=%h pop=%0d ham=%0d fire=%0d want %h 32 32 0",
                         hv_out, popcount, hamming, fire_count, PG); end
    n_tests++; if (abort_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_abort: got %0d want 0", abort_cnt); end
    consume();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_xor_stream();
    test_hamming();
    test_backpressure();
    test_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
